bist_mem_responder: RTL and testbench

- Memory-side responder for the BIST memory interface. Receives read and write requests from the march generator and returns mem_ready and mem_rdata after a fixed latency.
- Backed by a synthesizable single-port array. Used as the device-under-test memory model in 10_Memory_BIST benches and as the wrapper in front of real SRAM macros.
- Tracks access counts and flags protocol violations from the requester.

---
 rtl/bist_pkg.sv | 26 ++
 rtl/bist_fault_mask.sv | 60 ++++++
 rtl/bist_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_bist_mem_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared definitions for the BIST memory responder slice.
//
// Contents:
//   state_t         responder FSM states IDLE / WAIT / RESP / GAP
//   FT_*            fault type codes used when FAULT_INJECT_EN is defined
//   LATENCY_MIN/MAX legal range of the responder LATENCY parameter
//   LAT_CNT_W       width of the latency down-counter (holds LATENCY_MAX-1)
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [1:0] FT_SA0   = 2'd0;
  localparam logic [1:0] FT_SA1   = 2'd1;
  localparam logic [1:0] FT_TF_UP = 2'd2;
  localparam logic [1:0] FT_CFIN  = 2'd3;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int LAT_CNT_W   = 4;

endpackage

// File: rtl/bist_fault_mask.sv
// bist_fault_mask: combinational fault injection for the BIST memory responder.
// Only instantiated when FAULT_INJECT_EN is defined.
//
// Ports:
//   fault_en, fault_type, fault_addr, fault_bit   fault selection from the bench
//   acc_addr   address of the access being performed
//   rd_raw     fault-free stored word at acc_addr
//   wr_req     word the requester wants written
//   rd_data    read word after stuck-at masking
//   wr_data    word to store after transition-fault masking
//   cfin_flip  high when this write must invert the victim bit in the next cell
//   cfin_addr  victim cell address (fault_addr + 1, wrapping at the array depth)
//   bit_mask   one-hot mask of the faulty bit
module bist_fault_mask
  import bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          fault_en,
  input  logic [1:0]                    fault_type,
  input  logic [ADDR_WIDTH-1:0]         fault_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] fault_bit,
  input  logic [ADDR_WIDTH-1:0]         acc_addr,
  input  logic [DATA_WIDTH-1:0]         rd_raw,
  input  logic [DATA_WIDTH-1:0]         wr_req,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          cfin_flip,
  output logic [ADDR_WIDTH-1:0]         cfin_addr,
  output logic [DATA_WIDTH-1:0]         bit_mask
);

  logic hit;

  assign hit       = fault_en && (acc_addr == fault_addr);
  assign cfin_flip = hit && (fault_type == FT_CFIN);
  // Natural wrap of the ADDR_WIDTH adder makes the top cell's victim cell 0.
  assign cfin_addr = fault_addr + ADDR_WIDTH'(1);

  always_comb begin
    bit_mask            = '0;
    bit_mask[fault_bit] = 1'b1;
  end

  // A transition fault keeps a stored 0 at 0; the old value is the raw cell.
  always_comb begin
    rd_data = rd_raw;
    wr_data = wr_req;
    if (hit) begin
      case (fault_type)
        FT_SA0:   rd_data = rd_raw & ~bit_mask;
        FT_SA1:   rd_data = rd_raw | bit_mask;
        FT_TF_UP: wr_data = wr_req & (rd_raw | ~bit_mask);
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/bist_mem_responder.sv
// bist_mem_responder: memory-side responder for the BIST memory interface.
// Accepts level-held read/write requests, performs the access after a fixed
// LATENCY and returns a one-cycle mem_ready pulse followed by a one-cycle gap.
// Optional macro FAULT_INJECT_EN adds the fault_* ports and bist_fault_mask.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   mem_addr/read/write/wdata  request from the march generator
//   mem_rdata                  read data, held until the next read response
//   mem_ready                  one-cycle completion pulse
//   busy                       request in flight (WAIT, RESP, GAP)
//   protocol_err               sticky requester protocol violation flag
//   rd_count, wr_count         completed access counters (wrap)
//   fault_en/type/addr/bit     fault selection (FAULT_INJECT_EN only)
module bist_mem_responder
  import bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef FAULT_INJECT_EN
  input  logic                          fault_en,
  input  logic [1:0]                    fault_type,
  input  logic [ADDR_WIDTH-1:0]         fault_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] fault_bit,
`endif
  input  logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          mem_ready,
  output logic                          busy,
  output logic                          protocol_err,
  output logic [15:0]                   rd_count,
  output logic [15:0]                   wr_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_check
    $error("bist_mem_responder: LATENCY %0d outside %0d..%0d",
           LATENCY, LATENCY_MIN, LATENCY_MAX);
  end

  state_t                state, state_next;
  logic [LAT_CNT_W-1:0]  lat_cnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_write;
  logic                  accept;
  logic                  access;
  logic [DATA_WIDTH-1:0] rd_raw;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_data;

  // Storage is deliberately not reset; only written cells hold defined data.
  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  assign accept = (state == IDLE) && (mem_read || mem_write);
  assign access = (state == WAIT) && (lat_cnt == '0);
  assign rd_raw = mem_array[req_addr];

`ifdef FAULT_INJECT_EN
  logic                  cfin_flip;
  logic [ADDR_WIDTH-1:0] cfin_addr;
  logic [DATA_WIDTH-1:0] cfin_mask;

  bist_fault_mask #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fault_mask (
    .fault_en   (fault_en),
    .fault_type (fault_type),
    .fault_addr (fault_addr),
    .fault_bit  (fault_bit),
    .acc_addr   (req_addr),
    .rd_raw     (rd_raw),
    .wr_req     (req_wdata),
    .rd_data    (rd_data),
    .wr_data    (wr_data),
    .cfin_flip  (cfin_flip),
    .cfin_addr  (cfin_addr),
    .bit_mask   (cfin_mask)
  );
`else
  assign rd_data = rd_raw;
  assign wr_data = req_wdata;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: GAP ignores requests so a requester still holding its
  // request in the cycle after mem_ready is not accepted twice.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_read || mem_write) state_next = WAIT;
      WAIT:    if (lat_cnt == '0) state_next = RESP;
      RESP:    state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    mem_ready = (state == RESP);
    busy      = (state != IDLE);
  end

  // Request latch, latency counter, read data, counters and the sticky
  // protocol flag. The access always uses the latched request, so violations
  // are only recorded, never allowed to disturb the in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt      <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_write    <= 1'b0;
      mem_rdata    <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) begin
        req_addr  <= mem_addr;
        req_wdata <= mem_wdata;
        req_write <= mem_write;
        lat_cnt   <= LAT_CNT_W'(LATENCY - 1);
        if (mem_read && mem_write) begin
          protocol_err <= 1'b1;
        end
      end
      if (state == WAIT) begin
        if (lat_cnt != '0) begin
          lat_cnt <= lat_cnt - 1'b1;
        end
        if ((!mem_read && !mem_write) || (mem_addr != req_addr)) begin
          protocol_err <= 1'b1;
        end
      end
      if (access && !req_write) begin
        mem_rdata <= rd_data;
      end
      if (state == RESP) begin
        if (req_write) begin
          wr_count <= wr_count + 16'd1;
        end else begin
          rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

  // Array write port; a reset in the commit cycle cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && access && req_write) begin
      mem_array[req_addr] <= wr_data;
`ifdef FAULT_INJECT_EN
      if (cfin_flip) begin
        mem_array[cfin_addr] <= mem_array[cfin_addr] ^ cfin_mask;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bist_mem_responder.sv
// tb_bist_mem_responder: self-checking bench for bist_mem_responder.
// A transaction-level model predicts every output cycle by cycle from the
// accept cycle (ready at accept+LATENCY+1, busy until accept+LATENCY+2) and a
// shadow memory; directed literal checks pin the model on the key scenarios.
// Fault scenarios are compiled when FAULT_INJECT_EN is defined.
module tb_bist_mem_responder;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 1 << AW;
  localparam int FBW   = $clog2(DW);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  mem_addr = '0;
  logic           mem_read = 1'b0;
  logic           mem_write = 1'b0;
  logic [DW-1:0]  mem_wdata = '0;
  logic [DW-1:0]  mem_rdata;
  logic           mem_ready;
  logic           busy;
  logic           protocol_err;
  logic [15:0]    rd_count;
  logic [15:0]    wr_count;
  logic           fault_en = 1'b0;
  logic [1:0]     fault_type = 2'd0;
  logic [AW-1:0]  fault_addr = '0;
  logic [FBW-1:0] fault_bit = '0;

  bist_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LATENCY    (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FAULT_INJECT_EN
    .fault_en     (fault_en),
    .fault_type   (fault_type),
    .fault_addr   (fault_addr),
    .fault_bit    (fault_bit),
`endif
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .protocol_err (protocol_err),
    .rd_count     (rd_count),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  // Model state and per-cycle expectations.
  logic [DW-1:0] model_mem [DEPTH];
  bit            written [DEPTH];
  logic [AW-1:0] wq [$];
  logic [DW-1:0] model_rdata = '0;
  bit            model_err = 1'b0;
  logic [15:0]   model_rd = '0;
  logic [15:0]   model_wr = '0;
  logic          exp_ready = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_err = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  logic [15:0]   exp_rd = '0;
  logic [15:0]   exp_wr = '0;
  bit            check_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_pulses = 0;
  int last_ready_cyc = 0;
  int last_accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      ready_pulses++;
      last_ready_cyc = cyc;
    end
    if (check_en) begin
      checkOutput("mem_ready", mem_ready, exp_ready);
      checkOutput("busy", busy, exp_busy);
      checkOutput("protocol_err", protocol_err, exp_err);
      checkOutput("mem_rdata", mem_rdata, exp_rdata);
      checkOutput("rd_count", rd_count, exp_rd);
      checkOutput("wr_count", wr_count, exp_wr);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  function automatic logic [DW-1:0] bitOf(input logic [FBW-1:0] b);
    logic [DW-1:0] m;
    m    = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  function automatic bit faultHits(input logic [AW-1:0] a);
    return (fault_en == 1'b1) && (a == fault_addr);
  endfunction

  function automatic logic [DW-1:0] faultRead(input logic [AW-1:0] a, input logic [DW-1:0] v);
    if (faultHits(a) && fault_type == 2'd0) return v & ~bitOf(fault_bit);
    if (faultHits(a) && fault_type == 2'd1) return v | bitOf(fault_bit);
    return v;
  endfunction

  task automatic modelWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] v;
    logic [AW-1:0] nb;
    v = d;
    if (faultHits(a) && fault_type == 2'd2 && model_mem[a][fault_bit] == 1'b0) v[fault_bit] = 1'b0;
    model_mem[a] = v;
    if (faultHits(a) && fault_type == 2'd3) begin
      nb = a + 1'b1;
      model_mem[nb] = model_mem[nb] ^ bitOf(fault_bit);
    end
    if (!written[a]) begin
      written[a] = 1'b1;
      wq.push_back(a);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, AW'($urandom), $urandom);
      exp_busy  = 1'b0;
      exp_ready = 1'b0;
      nextCycle();
    end
  endtask

  task automatic doReset();
    check_en = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    nextCycle();
    nextCycle();
    model_rd = '0; model_wr = '0; model_err = 1'b0; model_rdata = '0;
    exp_ready = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
    exp_rdata = '0; exp_rd = '0; exp_wr = '0;
    check_en = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  // One request from accept (k=0) through GAP (k=LAT+2). drop_at/chg_at > 0
  // inject a dropped request or address change in that WAIT cycle; rst_at >= 0
  // asserts reset in that cycle and abandons the transaction.
  task automatic runTxn(input bit is_write, input bit both, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input int drop_at, input int chg_at,
                        input bit hold_gap, input int rst_at);
    logic [DW-1:0] rd_val;
    logic [AW-1:0] a_k;
    int            viol_at;
    bit            rq;
    rd_val  = faultRead(addr, model_mem[addr]);
    viol_at = both ? 1 : -1;
    if (drop_at > 0 && (viol_at < 0 || drop_at + 1 < viol_at)) viol_at = drop_at + 1;
    if (chg_at > 0 && (viol_at < 0 || chg_at + 1 < viol_at)) viol_at = chg_at + 1;
    for (int k = 0; k <= LAT + 2; k++) begin
      if (k == 0) last_accept_cyc = cyc;
      rq = (k <= LAT + 1) || hold_gap;
      if (drop_at > 0 && k >= drop_at) rq = 1'b0;
      a_k = (chg_at > 0 && k >= chg_at) ? (addr ^ AW'(1)) : addr;
      applyStimulus(rq && (!is_write || both), rq && is_write, a_k,
                    (k == 0) ? data : DW'($urandom));
      exp_busy  = (k >= 1);
      exp_ready = (k == LAT + 1);
      exp_rdata = (!is_write && k >= LAT + 1) ? rd_val : model_rdata;
      exp_rd    = model_rd + ((!is_write && k >= LAT + 2) ? 16'd1 : 16'd0);
      exp_wr    = model_wr + ((is_write && k >= LAT + 2) ? 16'd1 : 16'd0);
      exp_err   = model_err || (viol_at >= 0 && k >= viol_at);
      if (rst_at == k) rst = 1'b1;
      nextCycle();
      if (rst_at == k) begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        model_rd = '0; model_wr = '0; model_err = 1'b0; model_rdata = '0;
        exp_ready = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
        exp_rdata = '0; exp_rd = '0; exp_wr = '0;
        nextCycle();
        return;
      end
    end
    if (is_write) begin
      modelWrite(addr, data);
      model_wr = model_wr + 16'd1;
    end else begin
      model_rdata = rd_val;
      model_rd    = model_rd + 16'd1;
    end
    if (viol_at >= 0) model_err = 1'b1;
  endtask

  initial begin
    int p0;
    int r0;
    $display("[TB] bist_mem_responder bench, LATENCY=%0d", LAT);
    doReset();
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rdata", mem_rdata, 32'h0);
    checkOutput("reset_counts", {rd_count, wr_count}, 32'h0);

    // Write then read back-to-back.
    runTxn(1'b1, 1'b0, 10'd3, 32'hA5A5_A5A5, 0, 0, 1'b0, -1);
    runTxn(1'b0, 1'b0, 10'd3, '0, 0, 0, 1'b0, -1);
    checkOutput("wr_rd_rdata", mem_rdata, 32'hA5A5_A5A5);
    checkOutput("wr_rd_wr_count", wr_count, 32'd1);
    checkOutput("wr_rd_rd_count", rd_count, 32'd1);
    checkOutput("wr_rd_latency", last_ready_cyc - last_accept_cyc, 32'd5);

    // Request held through GAP at the top address: exactly one response.
    runTxn(1'b1, 1'b0, 10'h3FF, 32'hDEAD_BEEF, 0, 0, 1'b0, -1);
    p0 = ready_pulses;
    r0 = int'(rd_count);
    runTxn(1'b0, 1'b0, 10'h3FF, '0, 0, 0, 1'b1, -1);
    idleCycles(3);
    checkOutput("held_pulses", ready_pulses - p0, 32'd1);
    checkOutput("held_rd_count", int'(rd_count) - r0, 32'd1);
    checkOutput("held_latency", last_ready_cyc - last_accept_cyc, 32'd5);
    checkOutput("held_rdata", mem_rdata, 32'hDEAD_BEEF);

    // Randomised clean traffic, including immediate read-after-write.
    for (int t = 0; t < 200; t++) begin
      bit            do_write;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      do_write = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
      if (do_write) begin
        case ($urandom_range(0, 3))
          0:       a = '0;
          1:       a = '1;
          default: a = AW'($urandom);
        endcase
      end else begin
        a = wq[$urandom_range(0, wq.size() - 1)];
      end
      d = $urandom;
      runTxn(do_write, 1'b0, a, d, 0, 0, $urandom_range(0, 1) == 1, -1);
      if (do_write && $urandom_range(0, 3) == 0) runTxn(1'b0, 1'b0, a, '0, 0, 0, 1'b0, -1);
      idleCycles($urandom_range(0, 2));
    end

    // Reset in the middle of WAIT cancels the write and the response.
    runTxn(1'b1, 1'b0, 10'd3, 32'h1111_1111, 0, 0, 1'b0, -1);
    p0 = ready_pulses;
    runTxn(1'b1, 1'b0, 10'd3, 32'h2222_2222, 0, 0, 1'b0, 2);
    checkOutput("rstmid_busy", busy, 1'b0);
    checkOutput("rstmid_counts", {rd_count, wr_count}, 32'h0);
    checkOutput("rstmid_no_ready", ready_pulses - p0, 32'd0);
    runTxn(1'b0, 1'b0, 10'd3, '0, 0, 0, 1'b0, -1);
    checkOutput("rstmid_rdata", mem_rdata, 32'h1111_1111);

    // Read and write together: write wins, error sticks until reset.
    doReset();
    runTxn(1'b1, 1'b1, 10'd5, 32'h0000_0001, 0, 0, 1'b0, -1);
    checkOutput("both_err", protocol_err, 1'b1);
    runTxn(1'b0, 1'b0, 10'd5, '0, 0, 0, 1'b0, -1);
    checkOutput("both_rdata", mem_rdata, 32'h0000_0001);
    checkOutput("both_err_sticky", protocol_err, 1'b1);
    checkOutput("both_wr_count", wr_count, 32'd1);
    doReset();
    checkOutput("err_cleared", protocol_err, 1'b0);

    // Request dropped during WAIT, then address changed during WAIT.
    runTxn(1'b1, 1'b0, 10'd9, 32'hCAFE_0009, 0, 0, 1'b0, -1);
    runTxn(1'b0, 1'b0, 10'd9, '0, 2, 0, 1'b0, -1);
    checkOutput("drop_err", protocol_err, 1'b1);
    checkOutput("drop_rdata", mem_rdata, 32'hCAFE_0009);
    doReset();
    runTxn(1'b0, 1'b0, 10'd9, '0, 0, 1, 1'b0, -1);
    checkOutput("chg_err", protocol_err, 1'b1);
    checkOutput("chg_rdata", mem_rdata, 32'hCAFE_0009);
    doReset();

`ifdef FAULT_INJECT_EN
    // Stuck-at-1 on bit 0 of cell 7.
    runTxn(1'b1, 1'b0, 10'd7, 32'h0, 0, 0, 1'b0, -1);
    fault_type = 2'd1; fault_addr = 10'd7; fault_bit = 5'd0; fault_en = 1'b1;
    runTxn(1'b0, 1'b0, 10'd7, '0, 0, 0, 1'b0, -1);
    checkOutput("sa1_rdata", mem_rdata, 32'h0000_0001);
    fault_en = 1'b0;
    runTxn(1'b0, 1'b0, 10'd7, '0, 0, 0, 1'b0, -1);
    checkOutput("sa1_off_rdata", mem_rdata, 32'h0);
    // Transition fault: bit 4 of cell 20 cannot rise.
    runTxn(1'b1, 1'b0, 10'd20, 32'h0, 0, 0, 1'b0, -1);
    fault_type = 2'd2; fault_addr = 10'd20; fault_bit = 5'd4; fault_en = 1'b1;
    runTxn(1'b1, 1'b0, 10'd20, 32'hFFFF_FFFF, 0, 0, 1'b0, -1);
    fault_en = 1'b0;
    runTxn(1'b0, 1'b0, 10'd20, '0, 0, 0, 1'b0, -1);
    checkOutput("tfup_rdata", mem_rdata, 32'hFFFF_FFEF);
    // Inversion coupling from the top cell wraps onto cell 0.
    runTxn(1'b1, 1'b0, 10'd0, 32'h0, 0, 0, 1'b0, -1);
    fault_type = 2'd3; fault_addr = 10'h3FF; fault_bit = 5'd31; fault_en = 1'b1;
    runTxn(1'b1, 1'b0, 10'h3FF, 32'h0000_1234, 0, 0, 1'b0, -1);
    fault_en = 1'b0;
    runTxn(1'b0, 1'b0, 10'd0, '0, 0, 0, 1'b0, -1);
    checkOutput("cfin_rdata", mem_rdata, 32'h8000_0000);
`endif

    idleCycles(2);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
